alu_arbiter: RTL and testbench

- Round-robin scheduler that shares one combinational ALU among n_req requesters.
- Each requester offers an operand set {a, b, fct} over a valid/ready handshake.
- The block registers the winner's operands and drives the ALU for one cycle.
- It captures the ALU result into a response register tagged with the requester id.
- It sits between the client ports and the alu instance, replacing the single-user fsm/register front end.

---
 rtl/calc_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/alu_arbiter.sv | 155 +++++++++++++++
 tb/tb_alu_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and helpers for the ALU request arbiter.
package calc_pkg;

  localparam int unsigned FCT_W = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  // Requester index width; a single requester still gets a 1-bit id.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request strictly after last_i, wrapping to 0.
module rr_arbiter #(
  parameter int unsigned NReq = 4,
  parameter int unsigned IdW  = 2
) (
  input  logic [NReq-1:0] req_i,
  input  logic [IdW-1:0]  last_i,
  output logic [NReq-1:0] gnt_o,
  output logic [IdW-1:0]  idx_o,
  output logic            any_o
);

  // Two passes: indices above last_i first, then the wrapped range 0..last_i.
  always_comb begin
    int last_int;
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    last_int = int'(last_i);
    for (int k = 0; k < int'(NReq); k++) begin
      if (!any_o && req_i[k] && (k > last_int)) begin
        gnt_o[k] = 1'b1;
        idx_o    = IdW'(k);
        any_o    = 1'b1;
      end
    end
    for (int k = 0; k < int'(NReq); k++) begin
      if (!any_o && req_i[k] && (k <= last_int)) begin
        gnt_o[k] = 1'b1;
        idx_o    = IdW'(k);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among n_req requesters with round-robin priority.
// Each accepted operation takes one EXEC cycle, then waits in RESP for the consumer.
module alu_arbiter
  import calc_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter int unsigned n_req = 4,
  parameter int unsigned cnt_w = 16,
  localparam int unsigned id_w = id_width(n_req)
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [n_req-1:0]       req_valid_i,
  output logic [n_req-1:0]       req_ready_o,
  input  logic [n_req*width-1:0] req_a_i,
  input  logic [n_req*width-1:0] req_b_i,
  input  logic [2*n_req-1:0]     req_fct_i,
  output logic [width-1:0]       alu_a_o,
  output logic [width-1:0]       alu_b_o,
  output logic [FCT_W-1:0]       alu_fct_o,
  input  logic [2*width-1:0]     alu_s_i,
  input  logic                   alu_signal_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [id_w-1:0]        rsp_id_o,
  output logic [2*width-1:0]     rsp_s_o,
  output logic                   rsp_signal_o,
  output logic                   busy_o,
  output logic [cnt_w-1:0]       done_cnt_o
);

  // Requester 0 wins first after reset.
  localparam logic [id_w-1:0] LastRst = id_w'(n_req - 1);

  state_e               state_q, state_d;
  logic [id_w-1:0]      last_q;
  logic [id_w-1:0]      id_q;
  logic [width-1:0]     a_q, b_q;
  logic [FCT_W-1:0]     fct_q;
  logic [2*width-1:0]   s_q;
  logic                 sig_q;
  logic [cnt_w-1:0]     cnt_q;

  logic [n_req-1:0]     win_gnt;
  logic [id_w-1:0]      win_idx;
  logic                 any_req;
  logic                 accept;
  logic                 rsp_fire;
  logic [width-1:0]     a_sel, b_sel;
  logic [FCT_W-1:0]     fct_sel;

  rr_arbiter #(
    .NReq (n_req),
    .IdW  (id_w)
  ) u_rr_arbiter (
    .req_i  (req_valid_i),
    .last_i (last_q),
    .gnt_o  (win_gnt),
    .idx_o  (win_idx),
    .any_o  (any_req)
  );

  // Accept is possible in IDLE, or in RESP on the same cycle the response is taken.
  always_comb begin
    rsp_fire = (state_q == StResp) && rsp_ready_i;
    accept   = any_req && ((state_q == StIdle) || rsp_fire);
  end

  // Operand mux driven by the one-hot grant.
  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    fct_sel = '0;
    for (int k = 0; k < int'(n_req); k++) begin
      if (win_gnt[k]) begin
        a_sel   = req_a_i[k*width +: width];
        b_sel   = req_b_i[k*width +: width];
        fct_sel = req_fct_i[k*FCT_W +: FCT_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (any_req) state_d = StExec;
      StExec: state_d = StResp;
      StResp: if (rsp_ready_i) state_d = any_req ? StExec : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    req_ready_o = accept ? win_gnt : '0;
    rsp_valid_o = (state_q == StResp);
    busy_o      = (state_q != StIdle);
  end

  // Latch the winner's operands and remember it for the next arbitration round.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      a_q    <= '0;
      b_q    <= '0;
      fct_q  <= '0;
      id_q   <= '0;
      last_q <= LastRst;
    end else if (accept) begin
      a_q    <= a_sel;
      b_q    <= b_sel;
      fct_q  <= fct_sel;
      id_q   <= win_idx;
      last_q <= win_idx;
    end
  end

  // Capture the ALU result at the end of the EXEC cycle.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      s_q   <= '0;
      sig_q <= 1'b0;
    end else if (state_q == StExec) begin
      s_q   <= alu_s_i;
      sig_q <= alu_signal_i;
    end
  end

  // Saturating count of completed response handshakes.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
    end else if (rsp_fire && (cnt_q != {cnt_w{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign alu_fct_o    = fct_q;
  assign rsp_id_o     = id_q;
  assign rsp_s_o      = s_q;
  assign rsp_signal_o = sig_q;
  assign done_cnt_o   = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a 4-requester instance plus a 1-requester,
// 3-bit-counter instance for saturation. ALU stub: s = {a, b}, signal = ^fct.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  valid;
  logic [3:0]  ready;
  logic [31:0] req_a, req_b;
  logic [7:0]  req_fct;
  logic [7:0]  alu_a, alu_b;
  logic [1:0]  alu_fct;
  logic [15:0] alu_s;
  logic        alu_sig;
  logic        rsp_valid, rsp_ready, rsp_signal, busy;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_s;
  logic [15:0] done_cnt;

  // Saturation instance signals.
  logic        s_rst_n;
  logic        s_valid, s_ready_o;
  logic [7:0]  s_a, s_b;
  logic [1:0]  s_fct;
  logic [7:0]  s_alu_a, s_alu_b;
  logic [1:0]  s_alu_fct;
  logic [15:0] s_alu_s;
  logic        s_alu_sig;
  logic        s_rsp_valid, s_rsp_ready, s_rsp_signal, s_busy;
  logic        s_rsp_id;
  logic [15:0] s_rsp_s;
  logic [2:0]  s_done;

  int n_chk;
  int n_fail;

  assign alu_s     = {alu_a, alu_b};
  assign alu_sig   = ^alu_fct;
  assign s_alu_s   = {s_alu_a, s_alu_b};
  assign s_alu_sig = ^s_alu_fct;

  alu_arbiter #(
    .width (8),
    .n_req (4),
    .cnt_w (16)
  ) dut (
    .clock_i      (clk),
    .reset_i      (rst_n),
    .req_valid_i  (valid),
    .req_ready_o  (ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_fct_i    (req_fct),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_fct_o    (alu_fct),
    .alu_s_i      (alu_s),
    .alu_signal_i (alu_sig),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_s_o      (rsp_s),
    .rsp_signal_o (rsp_signal),
    .busy_o       (busy),
    .done_cnt_o   (done_cnt)
  );

  alu_arbiter #(
    .width (8),
    .n_req (1),
    .cnt_w (3)
  ) dut_sat (
    .clock_i      (clk),
    .reset_i      (s_rst_n),
    .req_valid_i  (s_valid),
    .req_ready_o  (s_ready_o),
    .req_a_i      (s_a),
    .req_b_i      (s_b),
    .req_fct_i    (s_fct),
    .alu_a_o      (s_alu_a),
    .alu_b_o      (s_alu_b),
    .alu_fct_o    (s_alu_fct),
    .alu_s_i      (s_alu_s),
    .alu_signal_i (s_alu_sig),
    .rsp_valid_o  (s_rsp_valid),
    .rsp_ready_i  (s_rsp_ready),
    .rsp_id_o     (s_rsp_id),
    .rsp_s_o      (s_rsp_s),
    .rsp_signal_o (s_rsp_signal),
    .busy_o       (s_busy),
    .done_cnt_o   (s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_chk++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    s_rst_n   = 1'b0;
    valid     = '0;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    req_fct   = '0;
    s_valid   = 1'b0;
    s_rsp_ready = 1'b1;
    s_a       = 8'hA5;
    s_b       = 8'h5A;
    s_fct     = 2'b11;

    // 1: reset state
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_done", 32'(done_cnt), 32'd0);
    chk("rst_ready", 32'(ready), 32'h0);
    rst_n   = 1'b1;
    s_rst_n = 1'b1;
    tick();

    // 2: single request from requester 2
    req_a[2*8 +: 8]   = 8'h05;
    req_b[2*8 +: 8]   = 8'h03;
    req_fct[2*2 +: 2] = 2'b01;
    valid = 4'b0100;
    #1;
    chk("t2_ready", 32'(ready), 32'h4);
    tick();
    valid = '0;
    chk("t2_exec_busy", 32'(busy), 32'd1);
    chk("t2_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t2_alu_a", 32'(alu_a), 32'h05);
    chk("t2_alu_b", 32'(alu_b), 32'h03);
    chk("t2_alu_fct", 32'(alu_fct), 32'h1);
    tick();
    chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t2_rsp_id", 32'(rsp_id), 32'd2);
    chk("t2_rsp_s", 32'(rsp_s), 32'h0503);
    chk("t2_rsp_signal", 32'(rsp_signal), 32'd1);
    tick();
    chk("t2_done", 32'(done_cnt), 32'd1);
    chk("t2_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t2_idle_busy", 32'(busy), 32'd0);

    // 3: all four valid from fresh reset -> grants 0,1,2,3,0,1
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_a[k*8 +: 8]   = 8'(8'h10 + k);
      req_b[k*8 +: 8]   = 8'(8'h20 + k);
      req_fct[k*2 +: 2] = 2'(k);
    end
    valid = 4'hF;
    #1;
    chk("t3_ready0", 32'(ready), 32'h1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t3_exec_alu_a", 32'(alu_a), 32'h10 + 32'(i % 4));
      chk("t3_exec_rsp_valid", 32'(rsp_valid), 32'd0);
      tick();
      chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t3_rsp_id", 32'(rsp_id), 32'(i % 4));
      chk("t3_rsp_s", 32'(rsp_s), {16'h0, 8'(8'h10 + i % 4), 8'(8'h20 + i % 4)});
      if (i == 5) begin
        valid = '0;
        #1;
        chk("t3_ready_last", 32'(ready), 32'h0);
      end else begin
        chk("t3_ready_next", 32'(ready), 32'(1 << ((i + 1) % 4)));
      end
    end
    tick();
    chk("t3_done", 32'(done_cnt), 32'd6);
    chk("t3_idle_busy", 32'(busy), 32'd0);

    // 4: response back-pressure with requester 1 pending
    rsp_ready = 1'b0;
    valid     = 4'b0010;
    #1;
    chk("t4_ready_idle", 32'(ready), 32'h2);
    tick();
    tick();
    chk("t4_rsp_id", 32'(rsp_id), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t4_hold_s", 32'(rsp_s), 32'h1121);
      chk("t4_hold_ready", 32'(ready), 32'h0);
      tick();
    end
    chk("t4_hold_valid_end", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    #1;
    chk("t4_release_ready", 32'(ready), 32'h2);
    tick();
    valid = '0;
    chk("t4_exec_done", 32'(done_cnt), 32'd7);
    chk("t4_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("t4_rsp2_id", 32'(rsp_id), 32'd1);
    tick();
    chk("t4_done", 32'(done_cnt), 32'd8);

    // 5: asynchronous reset during EXEC discards the operation
    valid = 4'b1000;
    #1;
    chk("t5_ready3", 32'(ready), 32'h8);
    tick();
    valid = '0;
    chk("t5_exec_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_async_done", 32'(done_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
      chk("t5_no_busy", 32'(busy), 32'd0);
    end
    valid = 4'b1001;
    #1;
    chk("t5_ready0", 32'(ready), 32'h1);
    tick();
    valid = '0;
    chk("t5_alu_a", 32'(alu_a), 32'h10);
    tick();
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t5_rsp_id", 32'(rsp_id), 32'd0);
    tick();

    // 6: single requester, 3-bit saturating counter
    s_valid = 1'b1;
    #1;
    chk("t6_ready", 32'(s_ready_o), 32'd1);
    tick();
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("t6_rsp_valid", 32'(s_rsp_valid), 32'd1);
      chk("t6_rsp_id", 32'(s_rsp_id), 32'd0);
      chk("t6_rsp_s", 32'(s_rsp_s), 32'hA55A);
      if (i == 9) s_valid = 1'b0;
      tick();
      chk("t6_done", 32'(s_done), (i > 7) ? 32'd7 : 32'(i));
    end
    chk("t6_idle_busy", 32'(s_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
